// File: rtl/rr_mux.sv
// N-input registered multiplexer with valid/ready handshakes and a round-robin arbiter.
// Define RR_MUX_FIXED_PRIO_EN to build a fixed-priority arbiter (lowest valid index wins) instead.
module rr_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  data_reg, data_next;
    logic [SW-1:0] sel_reg, sel_next;
    logic [W-1:0]  chan_data [N];
    logic          load;
    logic          grant_found;
    logic [SW-1:0] grant_idx;

    assign load = (state_reg == EMPTY) | out_ready;

    // in_ready depends only on in_valid, the pointer and the output state, never on in_data.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*W +: W];
            assign in_ready[gi]  = load & grant_found & ~rst & (grant_idx == SW'(gi));
        end
    endgenerate

`ifdef RR_MUX_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = SW'(i);
            end
        end
    end
`else
    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    logic [SW-1:0] ptr_reg, ptr_next;
    logic [SW:0]   cand;

    // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N never aliases.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_reg} + (SW+1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!grant_found && in_valid[cand[SW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (load && grant_found) begin
            ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            sel_reg   <= sel_next;
        end
    end

    // An empty-handed load drains the register but keeps the last data and index visible.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        sel_next   = sel_reg;
        if (load) begin
            if (grant_found) begin
                state_next = FULL;
                data_next  = chan_data[grant_idx];
                sel_next   = grant_idx;
            end else begin
                state_next = EMPTY;
            end
        end
    end

    always_comb begin
        out_valid = (state_reg == FULL);
        out_data  = data_reg;
        out_sel   = sel_reg;
    end

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: directed vector table, an N=3 wrap sequence and
// randomized traffic against a behavioural model of the arbitration rules.
module tb_rr_mux;

`ifdef RR_MUX_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst4, ready4, valid_o4;
    logic [31:0] data4;
    logic [3:0]  valid4, in_ready4;
    logic [7:0]  out_data4;
    logic [1:0]  out_sel4;

    logic        rst3, ready3, valid_o3;
    logic [47:0] data3;
    logic [2:0]  valid3, in_ready3;
    logic [15:0] out_data3;
    logic [1:0]  out_sel3;

    int n_vec = 0;
    int n_bad = 0;

    rr_mux #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst(rst4), .in_data(data4), .in_valid(valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(valid_o4), .out_ready(ready4), .out_sel(out_sel4)
    );

    rr_mux #(.N(3), .W(16)) dut3 (
        .clk(clk), .rst(rst3), .in_data(data3), .in_valid(valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(valid_o3), .out_ready(ready3), .out_sel(out_sel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ready;
        logic [3:0]  ir;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  os;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                                input logic rdy, input logic [3:0] ir, input logic ov,
                                input logic [7:0] od, input logic [1:0] os);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.ready = rdy;
        t.ir = ir; t.ov = ov; t.od = od; t.os = os;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply4(input logic r, input logic [3:0] v, input logic [31:0] d,
                          input logic rdy, input logic [3:0] eir, input logic eov,
                          input logic [7:0] eod, input logic [1:0] eos);
        @(negedge clk);
        rst4 = r; valid4 = v; data4 = d; ready4 = rdy;
        #1;
        chk("in_ready", 32'(in_ready4), 32'(eir));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(valid_o4), 32'(eov));
        chk("out_data", 32'(out_data4), 32'(eod));
        chk("out_sel", 32'(out_sel4), 32'(eos));
        $display("vec rst=%b valid=%b ready=%b -> in_ready=%b out_valid=%b out_data=%h out_sel=%0d",
                 r, v, rdy, eir, eov, eod, eos);
    endtask

    task automatic apply3(input logic r, input logic [2:0] v, input logic [2:0] eir,
                          input logic eov, input logic [15:0] eod, input logic [1:0] eos);
        @(negedge clk);
        rst3 = r; valid3 = v; ready3 = 1'b1;
        #1;
        chk("n3_in_ready", 32'(in_ready3), 32'(eir));
        @(posedge clk);
        #1;
        chk("n3_out_valid", 32'(valid_o3), 32'(eov));
        chk("n3_out_data", 32'(out_data3), 32'(eod));
        chk("n3_out_sel", 32'(out_sel3), 32'(eos));
        $display("n3 rst=%b valid=%b -> in_ready=%b out_data=%h out_sel=%0d", r, v, eir, eod, eos);
    endtask

    // Behavioural model state for the randomized phase.
    int          m_ptr;
    logic        m_v;
    logic [7:0]  m_d;
    logic [1:0]  m_s;

    initial begin
        logic [31:0] dd, da;
        logic [2:0]  e3;
        rst4 = 1'b1; valid4 = '0; data4 = '0; ready4 = 1'b0;
        rst3 = 1'b1; valid3 = '0; data3 = '0; ready3 = 1'b0;

        dd = 32'h13121110;
        da = 32'h00A50000;
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 4'hF, dd, 1, 4'h0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 4'h0, dd, 1, 4'h0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 4'b0100, da, 1, 4'b0100, 1, 8'hA5, 2'd2));
        tbl.push_back(mk(0, 4'h0, da, 0, 4'h0, 1, 8'hA5, 2'd2));
        tbl.push_back(mk(1, 4'hF, dd, 1, 4'h0, 0, 8'h00, 2'd0));
        for (int k = 0; k < 8; k++) begin
            int g;
            g = FIXED ? 0 : k % 4;
            tbl.push_back(mk(0, 4'hF, dd, 1, 4'(1 << g), 1, 8'(8'h10 + g), 2'(g)));
        end
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 4'hF, dd, 0, 4'h0, 1, FIXED ? 8'h10 : 8'h13, FIXED ? 2'd0 : 2'd3));
        tbl.push_back(mk(0, 4'hF, dd, 1, 4'b0001, 1, 8'h10, 2'd0));
        tbl.push_back(mk(0, 4'b1010, dd, 1, 4'b0010, 1, 8'h11, 2'd1));
        tbl.push_back(mk(0, 4'b1010, dd, 1, FIXED ? 4'b0010 : 4'b1000, 1,
                         FIXED ? 8'h11 : 8'h13, FIXED ? 2'd1 : 2'd3));
        tbl.push_back(mk(0, 4'b1110, dd, 1, 4'b0010, 1, 8'h11, 2'd1));

        foreach (tbl[i])
            apply4(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].ready,
                   tbl[i].ir, tbl[i].ov, tbl[i].od, tbl[i].os);

        // N=3: channels 1 and 2 contend; the pointer must wrap from 2 back to 0, not to 3.
        data3 = {16'h2222, 16'h1111, 16'h0000};
        apply3(1, 3'b110, 3'b000, 0, 16'h0000, 2'd0);
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (FIXED || (k % 2 == 0)) ? 1 : 2;
            e3 = 3'(1 << g);
            apply3(0, 3'b110, e3, 1, (g == 1) ? 16'h1111 : 16'h2222, 2'(g));
        end
        apply3(0, 3'b001, 3'b001, 1, 16'h0000, 2'd0);

        // Randomized traffic against the arbitration rules.
        apply4(1, 4'h0, 32'h0, 1, 4'h0, 0, 8'h00, 2'd0);
        m_ptr = 0; m_v = 1'b0; m_d = '0; m_s = '0;
        for (int n = 0; n < 400; n++) begin
            logic        r, rdy, load;
            logic [3:0]  v, eir;
            logic [31:0] d;
            int          g;
            r   = ($urandom_range(0, 31) == 0);
            v   = 4'($urandom);
            d   = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            load = !m_v || rdy;
            g = -1;
            if (!r && load) begin
                for (int i = 0; i < 4; i++) begin
                    int c;
                    c = FIXED ? i : (m_ptr + i) % 4;
                    if (g < 0 && v[c]) g = c;
                end
            end
            eir = (g >= 0) ? 4'(1 << g) : 4'h0;
            if (r) begin
                m_v = 1'b0; m_d = '0; m_s = '0; m_ptr = 0;
            end else if (load) begin
                if (g >= 0) begin
                    m_v = 1'b1; m_d = d[g*8 +: 8]; m_s = 2'(g); m_ptr = (g + 1) % 4;
                end else begin
                    m_v = 1'b0;
                end
            end
            apply4(r, v, d, rdy, eir, m_v, m_d, m_s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
